// File: rtl/car_alarm_controller.sv
// Car alarm sequencer: key-fob arm/disarm, exit/entry delays, bounded siren and re-arm.
// Optional arm/disarm confirmation chirp is built only when CAR_ALARM_CHIRP_EN is defined.
module car_alarm_controller #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXIT_DELAY  = 4,
  parameter int unsigned ENTRY_DELAY = 3,
  parameter int unsigned SIREN_TIME  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ArmRequest,
  input  logic       DisarmRequest,
  input  logic       OpenDoorSign,
  input  logic       IgnitionSignalOn,
  input  logic       CarLightsOnSign,
  output logic       SirenOn,
  output logic       ArmedLed,
  output logic       LightsChime,
  output logic       Chirp,
  output logic [2:0] AlarmState
);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

  // Expiry compares against DELAY-1, so each timed state lasts exactly DELAY cycles.
  localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LAST = CNT_W'(SIREN_TIME - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             exit_exp;
  logic             entry_exp;
  logic             siren_exp;

  assign exit_exp  = (cnt == EXIT_LAST);
  assign entry_exp = (cnt == ENTRY_LAST);
  assign siren_exp = (cnt == SIREN_LAST);

  // State, counter and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_DISARMED;
      cnt         <= '0;
      SirenOn     <= 1'b0;
      ArmedLed    <= 1'b0;
      LightsChime <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      SirenOn     <= (state_next == ST_ALARM);
      ArmedLed    <= (state_next == ST_ARMED) || (state_next == ST_ENTRY) ||
                     (state_next == ST_ALARM);
      LightsChime <= CarLightsOnSign & OpenDoorSign & ~IgnitionSignalOn;
    end
  end

  assign AlarmState = state;

  // Next-state and counter logic; disarm outranks every other transition.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;

    if (DisarmRequest && (state != ST_DISARMED)) begin
      state_next = ST_DISARMED;
    end else begin
      case (state)
        ST_DISARMED: if (ArmRequest && !IgnitionSignalOn) state_next = ST_EXIT;
        ST_EXIT:     if (exit_exp && !OpenDoorSign)       state_next = ST_ARMED;
        ST_ARMED: begin
          if (IgnitionSignalOn)  state_next = ST_ALARM;
          else if (OpenDoorSign) state_next = ST_ENTRY;
        end
        ST_ENTRY:    if (IgnitionSignalOn || entry_exp)   state_next = ST_ALARM;
        ST_ALARM:    if (siren_exp)                       state_next = ST_ARMED;
        default:     state_next = ST_DISARMED;
      endcase
    end

    // An EXIT expiry with the door open restarts the exit window in place.
    if ((state_next != state) || ((state == ST_EXIT) && exit_exp)) begin
      cnt_next = '0;
    end else if ((state == ST_EXIT) || (state == ST_ENTRY) || (state == ST_ALARM)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

`ifdef CAR_ALARM_CHIRP_EN
  logic chirp_set;

  // Confirm a completed arm or a fob disarm from an armed state; no chirp on siren re-arm.
  always_comb begin
    chirp_set = 1'b0;
    if ((state == ST_EXIT) && (state_next == ST_ARMED)) begin
      chirp_set = 1'b1;
    end else if (DisarmRequest &&
                 ((state == ST_ARMED) || (state == ST_ENTRY) || (state == ST_ALARM))) begin
      chirp_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) Chirp <= 1'b0;
    else       Chirp <= chirp_set;
  end
`else
  assign Chirp = 1'b0;
`endif

endmodule

// File: tb/tb_car_alarm_controller.sv
// Scoreboard bench for car_alarm_controller: driver queues hand-computed expectations,
// a monitor pops one per cycle just after the clock edge and compares.
module tb_car_alarm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       ArmRequest, DisarmRequest, OpenDoorSign, IgnitionSignalOn, CarLightsOnSign;
  logic       SirenOn, ArmedLed, LightsChime, Chirp;
  logic [2:0] AlarmState;

  car_alarm_controller dut (
    .clk             (clk),
    .reset           (reset),
    .ArmRequest      (ArmRequest),
    .DisarmRequest   (DisarmRequest),
    .OpenDoorSign    (OpenDoorSign),
    .IgnitionSignalOn(IgnitionSignalOn),
    .CarLightsOnSign (CarLightsOnSign),
    .SirenOn         (SirenOn),
    .ArmedLed        (ArmedLed),
    .LightsChime     (LightsChime),
    .Chirp           (Chirp),
    .AlarmState      (AlarmState)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       chime;
    logic       chirp;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_vec(input string tag, input logic [2:0] est,
                           input logic echime, input logic echirp);
    logic esiren;
    logic eled;
    logic echirp_b;
    esiren = (est == 3'd4);
    eled   = (est == 3'd2) || (est == 3'd3) || (est == 3'd4);
`ifdef CAR_ALARM_CHIRP_EN
    echirp_b = echirp;
`else
    echirp_b = 1'b0;
`endif
    n_cmp++;
    if ({AlarmState, SirenOn, ArmedLed, LightsChime, Chirp} !==
        {est, esiren, eled, echime, echirp_b}) begin
      n_bad++;
      $display("FAIL %s: got state=%0d siren=%b led=%b chime=%b chirp=%b, need state=%0d siren=%b led=%b chime=%b chirp=%b",
               tag, AlarmState, SirenOn, ArmedLed, LightsChime, Chirp,
               est, esiren, eled, echime, echirp_b);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic a, input logic d, input logic o, input logic i,
                      input logic l, input logic [2:0] es, input logic ec, input string tag);
    exp_t e;
    @(negedge clk);
    ArmRequest       = a;
    DisarmRequest    = d;
    OpenDoorSign     = o;
    IgnitionSignalOn = i;
    CarLightsOnSign  = l;
    e.st    = es;
    e.chime = l & o & ~i;
    e.chirp = ec;
    e.tag   = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    @(posedge clk);
    #3;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_vec(e.tag, e.st, e.chime, e.chirp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, need finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset = 1'b1;
    ArmRequest = 1'b0; DisarmRequest = 1'b0; OpenDoorSign = 1'b0;
    IgnitionSignalOn = 1'b0; CarLightsOnSign = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("reset_hold", 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_vec("reset_release", 3'd0, 1'b0, 1'b0);

    // Clean arm: 4 cycles of EXIT then ARMED
    step(1,0,0,0,0, 3'd1, 0, "arm");
    step(0,0,0,0,0, 3'd1, 0, "exit_c1");
    step(0,0,0,0,0, 3'd1, 0, "exit_c2");
    step(0,0,0,0,0, 3'd1, 0, "exit_c3");
    step(0,0,0,0,0, 3'd2, 1, "armed_chirp");
    step(0,0,0,0,0, 3'd2, 0, "armed_hold");

    // Intrusion with door held open
    step(0,0,1,0,0, 3'd3, 0, "entry_c0");
    step(0,0,1,0,0, 3'd3, 0, "entry_c1");
    step(0,0,1,0,0, 3'd3, 0, "entry_c2");
    for (int k = 0; k < 5; k++) step(0,0,1,0,0, 3'd4, 0, "alarm_siren");
    step(0,0,1,0,0, 3'd2, 0, "rearm_no_chirp");
    step(0,0,1,0,0, 3'd3, 0, "reentry");

    // Disarm in the 2nd ENTRY cycle
    step(0,0,1,0,0, 3'd3, 0, "entry_2nd");
    step(0,1,1,0,0, 3'd0, 1, "disarm_entry");
    step(0,0,0,0,0, 3'd0, 0, "disarmed_idle");

    // Arm blocked by ignition, then arm with door open
    step(1,0,0,1,0, 3'd0, 0, "arm_ign_blocked");
    step(0,0,0,0,0, 3'd0, 0, "still_disarmed");
    step(1,0,1,0,0, 3'd1, 0, "arm_door_open");
    step(0,0,1,0,0, 3'd1, 0, "exit_open_c1");
    step(0,0,1,0,0, 3'd1, 0, "exit_open_c2");
    step(0,0,1,0,0, 3'd1, 0, "exit_open_c3");
    step(0,0,1,0,0, 3'd1, 0, "exit_restart");
    step(0,0,0,0,0, 3'd1, 0, "exit_closed_c1");
    step(0,0,0,0,0, 3'd1, 0, "exit_closed_c2");
    step(0,0,0,0,0, 3'd1, 0, "exit_closed_c3");
    step(0,0,0,0,0, 3'd2, 1, "armed_after_close");

    // Hot-wire and disarm out of ALARM
    step(0,0,0,1,0, 3'd4, 0, "hotwire");
    step(0,0,0,1,0, 3'd4, 0, "hotwire_hold");
    step(0,1,0,1,0, 3'd0, 1, "disarm_alarm");
    step(0,0,0,0,0, 3'd0, 0, "idle_after_alarm");

    // Lights chime
    step(0,0,1,0,1, 3'd0, 0, "chime_on");
    step(0,0,1,1,1, 3'd0, 0, "chime_ign");
    step(0,0,0,0,1, 3'd0, 0, "chime_door_closed");

    // Arm and disarm together in DISARMED, then disarm from EXIT
    step(1,1,0,0,0, 3'd1, 0, "arm_wins");
    step(0,1,0,0,0, 3'd0, 0, "disarm_exit");

    // Reach ALARM, then hit asynchronous reset mid-cycle
    step(1,0,0,0,0, 3'd1, 0, "arm2");
    step(0,0,0,0,0, 3'd1, 0, "arm2_c1");
    step(0,0,0,0,0, 3'd1, 0, "arm2_c2");
    step(0,0,0,0,0, 3'd1, 0, "arm2_c3");
    step(0,0,0,0,0, 3'd2, 1, "arm2_armed");
    step(0,0,0,1,0, 3'd4, 0, "arm2_hotwire");
    step(0,0,0,0,0, 3'd4, 0, "arm2_alarm");
    drain();
    reset = 1'b1;
    #1;
    check_vec("async_reset", 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_held", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(0,0,0,0,0, 3'd0, 0, "post_reset_idle");
    step(1,0,0,0,0, 3'd1, 0, "post_reset_arm");
    drain();

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, need 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
